// File: rtl/vga_timing_encoder.sv
// vga_timing_encoder
//   Parametrised VGA timing generator and pixel encoder. Free-running
//   horizontal/vertical counters (advanced by PIX_CE) feed a single register
//   stage that produces sync, visible-region flag and expanded colour.
//
//   Optional feature macro: VGA_ENC_PATTERN_EN
//     When defined, TPAT=1 substitutes 8 vertical full-scale colour bars for
//     CSEL. When undefined, TPAT is ignored.
//
// Ports
//   CLK          system clock (single domain)
//   RST          synchronous active-high reset
//   PIX_CE       pixel clock enable; nothing advances or loads while 0
//   CSEL[7:0]    colour select {R[2:0], G[2:0], B[1:0]} for (HCOORD, VCOORD)
//   TPAT         test-pattern select (only with VGA_ENC_PATTERN_EN)
//   HCOORD       current horizontal counter
//   VCOORD       current vertical counter
//   HSYNC/VSYNC  registered sync outputs, polarity set by HS_POL/VS_POL
//   RED/GREEN/BLUE registered CW-bit colour channels, zero outside ACTIVE
//   ACTIVE       registered visible-region flag
//   FRAME_START  one-CLK strobe while pixel (0,0) is on the outputs
module vga_timing_encoder #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int HS_POL    = 0,
  parameter int VS_POL    = 0,
  parameter int CW        = 4,
  parameter int CNT_W     = 10
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             PIX_CE,
  input  logic [7:0]       CSEL,
  input  logic             TPAT,
  output logic [CNT_W-1:0] HCOORD,
  output logic [CNT_W-1:0] VCOORD,
  output logic             HSYNC,
  output logic             VSYNC,
  output logic [CW-1:0]    RED,
  output logic [CW-1:0]    GREEN,
  output logic [CW-1:0]    BLUE,
  output logic             ACTIVE,
  output logic             FRAME_START
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  // Region bounds are compared one bit wider than the counters so that a
  // sync end equal to 2^CNT_W (zero back porch) does not wrap.
  localparam logic [CNT_W:0] H_VIS_B  = (CNT_W+1)'(H_VISIBLE);
  localparam logic [CNT_W:0] HS_BEG_B = (CNT_W+1)'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W:0] HS_END_B = (CNT_W+1)'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CNT_W:0] V_VIS_B  = (CNT_W+1)'(V_VISIBLE);
  localparam logic [CNT_W:0] VS_BEG_B = (CNT_W+1)'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W:0] VS_END_B = (CNT_W+1)'(V_VISIBLE + V_FRONT + V_SYNC);

  localparam logic HS_ACT = (HS_POL != 0);
  localparam logic VS_ACT = (VS_POL != 0);

  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] vcnt;
  logic [CNT_W:0]   hx;
  logic [CNT_W:0]   vx;

  logic             hs_on;
  logic             vs_on;
  logic             act_d;
  logic [7:0]       sel;

  // Cyclic MSB-first replication: the top CW bits of {f,f,f,...}.
  function automatic logic [CW-1:0] rep3(input logic [2:0] f);
    logic [3*CW-1:0] t;
    t = {CW{f}};
    return t[3*CW-1 -: CW];
  endfunction

  function automatic logic [CW-1:0] rep2(input logic [1:0] f);
    logic [2*CW-1:0] t;
    t = {CW{f}};
    return t[2*CW-1 -: CW];
  endfunction

  // Position counters
  always_ff @(posedge CLK) begin
    if (RST) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (PIX_CE) begin
      if (hcnt == H_LAST) begin
        hcnt <= '0;
        vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
      end else begin
        hcnt <= hcnt + 1'b1;
      end
    end
  end

  assign HCOORD = hcnt;
  assign VCOORD = vcnt;
  assign hx     = {1'b0, hcnt};
  assign vx     = {1'b0, vcnt};

`ifdef VGA_ENC_PATTERN_EN
  localparam int               BAR_WI  = ((H_VISIBLE >> 3) > 0) ? (H_VISIBLE >> 3) : 1;
  localparam logic [CNT_W-1:0] BAR_W   = CNT_W'(BAR_WI);
  localparam logic [CNT_W-1:0] BAR_MAX = CNT_W'(7);

  logic [CNT_W-1:0] bar_q;
  logic [2:0]       bar;
  logic [2:0]       bar_rgb;

  // Pixels past 8*BAR_W (H_VISIBLE not a multiple of 8) stay in the last bar.
  always_comb begin
    bar_q = hcnt / BAR_W;
    bar   = (bar_q > BAR_MAX) ? 3'd7 : bar_q[2:0];
    case (bar)
      3'd0:    bar_rgb = 3'b111;
      3'd1:    bar_rgb = 3'b110;
      3'd2:    bar_rgb = 3'b011;
      3'd3:    bar_rgb = 3'b010;
      3'd4:    bar_rgb = 3'b101;
      3'd5:    bar_rgb = 3'b100;
      3'd6:    bar_rgb = 3'b001;
      default: bar_rgb = 3'b000;
    endcase
  end

  // Replicated bits make every channel all-ones or all-zeros after expansion.
  assign sel = TPAT ? {{3{bar_rgb[2]}}, {3{bar_rgb[1]}}, {2{bar_rgb[0]}}} : CSEL;
`else
  logic unused_tpat;
  assign unused_tpat = TPAT;
  assign sel         = CSEL;
`endif

  always_comb begin
    hs_on = (hx >= HS_BEG_B) && (hx < HS_END_B);
    vs_on = (vx >= VS_BEG_B) && (vx < VS_END_B);
    act_d = (hx < H_VIS_B) && (vx < V_VIS_B);
  end

  // Output stage: loads on enabled cycles; FRAME_START is rewritten every
  // cycle so it lasts exactly one CLK even while the other outputs hold.
  always_ff @(posedge CLK) begin
    if (RST) begin
      HSYNC       <= ~HS_ACT;
      VSYNC       <= ~VS_ACT;
      RED         <= '0;
      GREEN       <= '0;
      BLUE        <= '0;
      ACTIVE      <= 1'b0;
      FRAME_START <= 1'b0;
    end else begin
      FRAME_START <= PIX_CE && (hcnt == '0) && (vcnt == '0);
      if (PIX_CE) begin
        HSYNC  <= hs_on ? HS_ACT : ~HS_ACT;
        VSYNC  <= vs_on ? VS_ACT : ~VS_ACT;
        ACTIVE <= act_d;
        RED    <= act_d ? rep3(sel[7:5]) : '0;
        GREEN  <= act_d ? rep3(sel[4:2]) : '0;
        BLUE   <= act_d ? rep2(sel[1:0]) : '0;
      end
    end
  end

endmodule

// File: doc/vga_timing_encoder.md
# vga_timing_encoder

Parametrised VGA timing generator and pixel encoder. It replaces the fixed 640x480 encoder with configurable horizontal/vertical timing, sync polarity and colour depth, and adds a pixel-clock enable and a frame-start strobe. It sits between the upstream pixel source, which computes `CSEL` from `HCOORD`/`VCOORD`, and the VGA DAC pins.

## Interface
Parameters:
- `H_VISIBLE`, 640: active pixels per line.
- `H_FRONT`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: horizontal sync width, in pixels.
- `H_BACK`, 48: horizontal back porch, in pixels.
- `V_VISIBLE`, 480: active lines per frame.
- `V_FRONT`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vertical sync width, in lines.
- `V_BACK`, 33: vertical back porch, in lines.
- `HS_POL`, 0: HSYNC active level (0 = active-low).
- `VS_POL`, 0: VSYNC active level (0 = active-low).
- `CW`, 4: bits per colour channel (≥3).
- `CNT_W`, 10: coordinate width. 2^CNT_W must exceed both H_TOTAL−1 and V_TOTAL−1.

Ports:
- `CLK` in 1: system clock. One clock domain.
- `RST` in 1: reset. Synchronous and active-high.
- `PIX_CE` in 1: pixel clock enable. The block advances only in cycles where it is 1.
- `CSEL` in 8: colour select {R[2:0], G[2:0], B[1:0]}.
- `TPAT` in 1: test-pattern select. Ignored unless the macro is defined.
- `HCOORD` out CNT_W: current horizontal counter.
- `VCOORD` out CNT_W: current vertical counter.
- `HSYNC` out 1: horizontal sync (registered).
- `VSYNC` out 1: vertical sync (registered).
- `RED` out CW: red channel (registered).
- `GREEN` out CW: green channel (registered).
- `BLUE` out CW: blue channel (registered).
- `ACTIVE` out 1: registered visible-region flag.
- `FRAME_START` out 1: one-CLK strobe marking pixel (0,0) on the outputs.

## Operation
- Totals: H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800). V_TOTAL is defined the same way (525).
- Line order: visible, then front porch, then sync, then back porch. Frame order is identical, in lines.
- Counters `hcnt`/`vcnt` drive `HCOORD`/`VCOORD` directly.
- When PIX_CE=1:
  - hcnt increments.
  - At H_TOTAL−1, hcnt wraps to 0 and vcnt increments.
  - When vcnt is at V_TOTAL−1 and hcnt wraps, vcnt wraps to 0.
- When PIX_CE=0: counters and all registered outputs hold.
- Stage 2 registers, loaded on PIX_CE=1 from the current counters and CSEL:
  - HSYNC = HS_POL when H_VISIBLE+H_FRONT ≤ hcnt < H_VISIBLE+H_FRONT+H_SYNC, else ~HS_POL.
  - VSYNC follows the same rule using vcnt and the V_* parameters.
  - ACTIVE = (hcnt < H_VISIBLE) && (vcnt < V_VISIBLE).
  - Colours are forced to 0 when not ACTIVE. Otherwise each field is expanded to CW bits by cyclic replication, MSB first.
  - Example, CW=4: R {r2,r1,r0,r2}; B {b1,b0,b1,b0}.
- FRAME_START = 1 only in the CLK cycle immediately after a PIX_CE=1 cycle with hcnt=0 and vcnt=0. It is 0 in all other cycles, even while outputs hold.
- Reset values: hcnt=vcnt=0; HSYNC=~HS_POL; VSYNC=~VS_POL; RED=GREEN=BLUE=0; ACTIVE=0; FRAME_START=0.
- RST overrides PIX_CE. A reset mid-frame restarts at (0,0) on the next enabled cycle.

## Timing
- Pixel latency is 1 enabled cycle. CSEL sampled while HCOORD=x, VCOORD=y appears on RED/GREEN/BLUE, together with the HSYNC/VSYNC/ACTIVE for (x,y), after that PIX_CE edge.
- Upstream must therefore produce CSEL combinationally, or with zero latency, from HCOORD/VCOORD.
- With PIX_CE tied to 1, CLK is the pixel clock: 25 MHz for 640x480@60.
- With PIX_CE=1 every Nth cycle, all periods scale by N and outputs are stable for N cycles.
- Default timing:
  - HSYNC asserted for 96 enabled cycles starting with the output for hcnt=656.
  - VSYNC asserted for lines 490–491.
  - Frame period is 420 000 enabled cycles.

## Configuration
- `VGA_ENC_PATTERN_EN` defined: TPAT=1 replaces CSEL with 8 vertical full-scale colour bars.
  - Bar index = min(hcnt / (H_VISIBLE>>3), 7).
  - Bar order 0–7 (RGB): white 111, yellow 110, cyan 011, green 010, magenta 101, red 100, blue 001, black 000.
  - Each channel is all-ones or all-zeros.
  - Latency and blanking are the same as the CSEL path.
- `VGA_ENC_PATTERN_EN` undefined: the pattern logic is absent, TPAT is ignored and CSEL is always used.

## Test plan
- Reset: hold RST=1 for 3 cycles with PIX_CE=1 → HCOORD=VCOORD=0, HSYNC=VSYNC=1, RGB=0, ACTIVE=0, FRAME_START=0.
- PIX_CE=1 and CSEL=8'hFF:
  - RGB=4'hF exactly when ACTIVE, and 0 in blanking.
  - HSYNC low for 96 cycles every 800.
  - VSYNC low for 1600 cycles every 420 000.
  - FRAME_START pulses every 420 000 cycles.
- CSEL=8'b00000010 → BLUE=4'b1010, RED=GREEN=0 during active video. CSEL=8'b10100000 → RED=4'b1011.
- PIX_CE=1 one cycle in four:
  - HSYNC period is 3200 CLKs.
  - Outputs change only after enabled edges.
  - FRAME_START is high for exactly 1 CLK per frame.
- Assert RST for 1 cycle at hcnt=300, vcnt=200 → next enabled cycle shows HCOORD=VCOORD=0, with sync outputs inactive in the meantime.
- With `VGA_ENC_PATTERN_EN` defined, TPAT=1: output for hcnt=85 is RED=GREEN=4'hF, BLUE=0. Output for hcnt=639 is all 0, with CSEL ignored.
